// File: rtl/ysyx_24120013_ifu_fetch_pkg.sv
// Shared fetch definitions: FSM encoding, PC constants and the memory
// request/response layout that the LSU reuses.
package ysyx_24120013_ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned MEM_AW           = 32'd32;
  localparam int unsigned MEM_DW           = 32'd32;

  typedef struct packed {
    logic              valid;
    logic [MEM_AW-1:0] addr;
  } mem_req_t;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [MEM_DW-1:0] data;
  } mem_rsp_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_24120013_ifu_fetch.sv
// Instruction fetch unit: one outstanding word fetch, valid/ready delivery of
// {inst, pc} to decode, redirects from execute and a sticky fetch error.
module ysyx_24120013_ifu_fetch
  import ysyx_24120013_ifu_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_err
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic                  r_pend_v;
  logic                  w_pend_v_nxt;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic [ADDR_WIDTH-1:0] w_pend_pc_nxt;
  logic                  r_discard;
  logic                  w_discard_nxt;
  logic [31:0]           r_inst;
  logic [31:0]           w_inst_nxt;
  logic [ADDR_WIDTH-1:0] r_inst_pc;
  logic [ADDR_WIDTH-1:0] w_inst_pc_nxt;
  logic                  r_inst_valid;
  logic                  r_fetch_err;
  logic                  r_live;

  logic                  w_redir;
  logic                  w_misal;
  logic                  w_req_fire;
  logic [ADDR_WIDTH-1:0] w_tgt;

  // r_live keeps the request low during the reset cycle without a path from rst.
  assign imem_req_valid = r_live & (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_err      = r_fetch_err;

  assign w_redir    = redirect_valid & (r_state != ST_ERR);
  assign w_misal    = w_redir & ~is_word_aligned(redirect_pc[1:0]);
  assign w_req_fire = imem_req_valid & imem_req_ready;

  // Next-state and datapath decode for the fetch FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_v_nxt  = r_pend_v;
    w_pend_pc_nxt = r_pend_pc;
    w_discard_nxt = r_discard;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    // A redirect arriving together with the dropped response is the newest target.
    if (redirect_valid) begin
      w_tgt = redirect_pc;
    end else begin
      w_tgt = r_pend_pc;
    end
    case (r_state)
      ST_REQ: begin
        if (w_misal) begin
          w_state_nxt = ST_ERR;
        end else begin
          if (w_redir) begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = redirect_pc;
          end else begin
            w_pend_v_nxt  = r_pend_v;
          end
          if (w_req_fire) begin
            w_state_nxt   = ST_WAIT;
            w_discard_nxt = r_pend_v | w_redir;
          end else begin
            w_state_nxt   = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        if (w_misal) begin
          w_state_nxt = ST_ERR;
        end else if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            w_state_nxt = ST_ERR;
          end else if (r_discard | w_redir) begin
            w_pc_nxt      = w_tgt;
            w_pend_v_nxt  = 1'b0;
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_REQ;
          end else begin
            w_inst_nxt    = imem_rsp_data[31:0];
            w_inst_pc_nxt = r_pc;
            w_state_nxt   = ST_OUT;
          end
        end else if (w_redir) begin
          w_pend_v_nxt  = 1'b1;
          w_pend_pc_nxt = redirect_pc;
          w_discard_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (w_misal) begin
          w_state_nxt = ST_ERR;
        end else if (w_redir) begin
          w_pc_nxt     = redirect_pc;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = ST_REQ;
        end else if (inst_ready) begin
          w_pc_nxt    = r_pc + ADDR_WIDTH'(INST_BYTES);
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  // State, PC and registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_pend_v     <= 1'b0;
      r_pend_pc    <= '0;
      r_discard    <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_live       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_discard    <= w_discard_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= (w_state_nxt == ST_OUT);
      r_fetch_err  <= (w_state_nxt == ST_ERR);
      r_live       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_ifu_fetch.sv
// Scoreboard bench for the fetch unit: a 1-cycle (or delayed) memory model,
// expected request addresses and delivered instructions queued per scenario.
module tb_ysyx_24120013_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];
  bit          force_ready = 1'b0;
  int          mem_lat = 0;
  bit          err_arm = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          cyc = 0;
  int          last_fire_cyc = 0;
  logic        prev_inst_valid = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;

  ysyx_24120013_ifu_fetch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  // Memory model: answers each accepted request after mem_lat extra cycles.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      m_pend = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = 32'h0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(m_addr);
          imem_rsp_err   = err_arm && (m_addr == err_addr);
          m_pend = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        m_pend = 1'b1; m_cnt = mem_lat; m_addr = imem_req_addr;
      end
    end
  end

  // Scoreboard: pops expected request addresses and delivered instructions.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ei;
    #2;
    cyc++;
    if (!rst) begin
      prev_inst_valid = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++; $display("FAIL req_addr: unexpected request addr=%h", imem_req_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (imem_req_addr !== ea) begin
            miscompares++; $display("FAIL req_addr: got %h expected %h", imem_req_addr, ea);
          end
        end
        last_fire_cyc = cyc;
      end
      if (inst_valid && !prev_inst_valid && mem_lat == 0) begin
        vectors++;
        if (cyc - last_fire_cyc != 2) begin
          miscompares++; $display("FAIL latency: got %0d cycles expected 2", cyc - last_fire_cyc);
        end
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (exp_inst_q.size() == 0) begin
          miscompares++; $display("FAIL inst: unexpected inst=%h pc=%h", inst, inst_pc);
        end else begin
          ei = exp_inst_q.pop_front();
          if ({inst, inst_pc} !== ei) begin
            miscompares++; $display("FAIL inst: got %h/%h expected %h/%h", inst, inst_pc, ei[63:32], ei[31:0]);
          end
        end
      end
      prev_inst_valid = inst_valid;
    end
  end

  task automatic step();
    @(negedge clk);
    imem_req_ready = force_ready || (exp_addr_q.size() != 0);
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_inst_q.push_back({mem_word(a), a});
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_addr_q.size() == 0 && exp_inst_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b0;
    force_ready = 1'b0; err_arm = 1'b0; mem_lat = 0;
    exp_addr_q.delete(); exp_inst_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 6;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL rst_fetch_err: got %b expected 0", fetch_err); end
    if (inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h expected 0", inst); end
    if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== RST_PC) begin miscompares++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
    rst = 1'b1;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      miscompares++; $display("FAIL first_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_fetch(RST_PC + 32'(4 * i), 1'b1);
    drain(60, ok);
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL seq_timeout: got pending expected drained"); end
    if (imem_req_addr !== 32'h8000_000C) begin miscompares++; $display("FAIL seq_next: got %h expected 8000000c", imem_req_addr); end
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    inst_ready = 1'b0;
    expect_fetch(32'h8000_000C, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = inst_valid;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL stall_timeout: got no inst_valid expected 1"); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst !== mem_word(32'h8000_000C) || inst_pc !== 32'h8000_000C || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b %h/%h req=%b expected 1 %h/8000000c 0", inst_valid, inst, inst_pc, imem_req_valid, mem_word(32'h8000_000C));
      end
      step();
    end
    inst_ready = 1'b1;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
      miscompares++; $display("FAIL stall_next: got %b/%h expected 1/80000010", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic redirect_in_wait(input logic [31:0] trig, input logic [31:0] t1,
                                  input logic [31:0] t2, input logic [31:0] park, input string nm);
    bit ok = 1'b0;
    int phase = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      redirect_valid = 1'b0;
      if (phase == 2) begin redirect_valid = 1'b1; redirect_pc = t2; phase = 3; end
      if (phase == 1) begin redirect_valid = 1'b1; redirect_pc = t1; phase = 2; end
      if (phase == 0 && imem_req_valid && imem_req_ready && imem_req_addr == trig) phase = 1;
      if (phase == 3 && !redirect_valid && exp_addr_q.size() == 0 && exp_inst_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL %s_timeout: got phase %0d expected drained", nm, phase); end
    if (imem_req_addr !== park) begin miscompares++; $display("FAIL %s_park: got %h expected %h", nm, imem_req_addr, park); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 2;
    expect_fetch(32'h8000_0000, 1'b1);
    expect_fetch(32'h8000_0004, 1'b0);
    expect_fetch(32'h8000_0100, 1'b1);
    expect_fetch(32'h8000_0104, 1'b1);
    redirect_in_wait(32'h8000_0004, 32'h8000_0100, 32'h8000_0100, 32'h8000_0108, "redir_wait");
    expect_fetch(32'h8000_0108, 1'b0);
    expect_fetch(32'h8000_0400, 1'b1);
    redirect_in_wait(32'h8000_0108, 32'h8000_0300, 32'h8000_0400, 32'h8000_0404, "redir_twice");
    mem_lat = 0;
  endtask

  task automatic test_redirect_out();
    bit ok;
    int phase = 0;
    inst_ready = 1'b1;
    expect_fetch(32'h8000_0404, 1'b1);
    for (int i = 0; i < 20 && phase != 2; i++) begin
      step();
      redirect_valid = 1'b0;
      if (phase == 1) begin
        phase = 2;
        vectors++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
          miscompares++; $display("FAIL redir_out: got v=%b req=%b/%h expected 0 1/80000200", inst_valid, imem_req_valid, imem_req_addr);
        end
      end
      if (phase == 0 && inst_valid) begin redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; phase = 1; end
    end
    vectors++;
    if (phase != 2) begin miscompares++; $display("FAIL redir_out_timeout: got phase %0d expected 2", phase); end
    expect_fetch(32'h8000_0200, 1'b1);
    drain(40, ok);
    vectors++;
    if (!ok || imem_req_addr !== 32'h8000_0204) begin miscompares++; $display("FAIL redir_out_next: got %h expected 80000204", imem_req_addr); end
  endtask

  task automatic test_redirect_req();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204) begin
      miscompares++; $display("FAIL redir_req_hold: got %b/%h expected 1/80000204", imem_req_valid, imem_req_addr);
    end
    expect_fetch(32'h8000_0204, 1'b0);
    expect_fetch(32'h8000_0500, 1'b1);
    expect_fetch(32'h8000_0504, 1'b1);
    drain(60, ok);
    vectors++;
    if (!ok || imem_req_addr !== 32'h8000_0508) begin miscompares++; $display("FAIL redir_req_next: got %h expected 80000508", imem_req_addr); end
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    err_arm = 1'b1; err_addr = 32'h8000_0004;
    expect_fetch(32'h8000_0000, 1'b1);
    expect_fetch(32'h8000_0004, 1'b0);
    drain(40, ok);
    force_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0600;
      step();
      vectors++;
      if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++; $display("FAIL err_sticky: got err=%b req=%b v=%b expected 1 0 0", fetch_err, imem_req_valid, inst_valid);
      end
    end
    redirect_valid = 1'b0; force_ready = 1'b0; err_arm = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++;
    if (fetch_err !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      miscompares++; $display("FAIL err_reset: got err=%b req=%b/%h expected 0 0/%h", fetch_err, imem_req_valid, imem_req_addr, RST_PC);
    end
    step();
    vectors++;
    if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL err_restart: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    force_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0) begin
        miscompares++; $display("FAIL misalign: got err=%b req=%b/%h expected 1 0", fetch_err, imem_req_valid, imem_req_addr);
      end
      step();
    end
    force_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    expect_fetch(32'h8000_0000, 1'b0);
    expect_fetch(32'hFFFF_FFFC, 1'b1);
    expect_fetch(32'h0000_0000, 1'b1);
    drain(60, ok);
    vectors++;
    if (!ok || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0004) begin
      miscompares++; $display("FAIL wrap: got %b/%h expected 1/00000004", imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_redirect_req();
    test_error();
    test_misaligned();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
